// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD text writer.
//   - lcd_state_e : writer FSM encoding (IDLE, CLEAR, DRAW, DONE)
//   - LCD_PAGES / LCD_COLS / FB_DEPTH : frame-buffer geometry
//   - lcd_fb_addr : maps (page, pixel column) to a frame-buffer byte address
//     in the order the display refresh reads it back.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } lcd_state_e;

  localparam int LCD_PAGES = 8;
  localparam int LCD_COLS  = 128;
  localparam int FB_DEPTH  = 1024;

  // Page bits are inverted and split around the column so that the RAM
  // layout matches the display read order.
  function automatic logic [9:0] lcd_fb_addr(input logic [2:0] page,
                                             input logic [6:0] col);
    return {~page[2:1], col, ~page[0]};
  endfunction

endpackage

// File: rtl/lcd_text_writer.sv
// lcd_text_writer: renders 8x8 glyphs into the 1024-byte LCD frame buffer, or
// clears the whole buffer, then pulses upd_done so the refresh can start.
//
// Handshake: a character request is taken on a rising sys_clk edge where
// char_valid and char_ready are both high; char_ready is high only in IDLE
// while clr_req is low, so a clear always wins over a simultaneous character.
//
// Ports:
//   sys_clk, reset_o (async, active-low)
//   char_valid/char_ready/char_code/char_row/char_col : character request
//   clr_req     : clear-screen request, sampled in IDLE only
//   font_addr   : {char_code, glyph column} to external font ROM
//   font_data   : registered ROM output, valid one cycle after font_addr
//   addr_write/data_write/write_en : frame-buffer write port
//   busy        : high outside IDLE
//   upd_done    : one-cycle pulse after the last write of a char or clear
//   fsm_state   : current FSM state (debug)
//
// Build option LCD_TEXT_INVERT_EN: adds input char_invert, latched at the
// handshake; when set the glyph is written as ~font_data (reverse video).
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter logic [7:0] CLEAR_BYTE = 8'h00,
  parameter int         COL_OFFSET = 0
) (
  input  logic        sys_clk,
  input  logic        reset_o,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [7:0]  char_code,
  input  logic [2:0]  char_row,
  input  logic [3:0]  char_col,
`ifdef LCD_TEXT_INVERT_EN
  input  logic        char_invert,
`endif
  input  logic        clr_req,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [9:0]  addr_write,
  output logic [7:0]  data_write,
  output logic        write_en,
  output logic        busy,
  output logic        upd_done,
  output logic [1:0]  fsm_state
);

  localparam logic [9:0] CLR_LAST  = 10'(FB_DEPTH - 1);
  localparam logic [9:0] DRAW_LAST = 10'd8;
  localparam int         ROW_W     = $clog2(LCD_PAGES);
  localparam int         PCOL_W    = $clog2(LCD_COLS);

  lcd_state_e         state, state_nx;
  logic [9:0]         cnt, cnt_nx;
  logic               accept;
  logic [7:0]         code_q;
  logic [ROW_W-1:0]   row_q;
  logic [3:0]         col_q;
  logic [2:0]         glyph_k;
  logic [PCOL_W-1:0]  pix_col;
  logic [7:0]         glyph_byte;

`ifdef LCD_TEXT_INVERT_EN
  logic inv_q;
  assign glyph_byte = inv_q ? ~font_data : font_data;
`else
  assign glyph_byte = font_data;
`endif

  // Writes trail the ROM address by one cycle, so write step k (cnt=1..8)
  // uses glyph column cnt-1; the 3-bit wrap turns cnt=8 into column 7.
  assign glyph_k = cnt[2:0] - 3'd1;
  assign pix_col = {col_q, 3'b000} + {4'b0000, glyph_k} + PCOL_W'(COL_OFFSET);

  assign fsm_state = state;

  always_ff @(posedge sys_clk or negedge reset_o) begin
    if (!reset_o) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      code_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
`ifdef LCD_TEXT_INVERT_EN
      inv_q  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        code_q <= char_code;
        row_q  <= char_row;
        col_q  <= char_col;
`ifdef LCD_TEXT_INVERT_EN
        inv_q  <= char_invert;
`endif
      end
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    accept     = 1'b0;
    char_ready = 1'b0;
    busy       = 1'b1;
    write_en   = 1'b0;
    addr_write = '0;
    data_write = '0;
    font_addr  = '0;
    upd_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        busy       = 1'b0;
        char_ready = ~clr_req;
        cnt_nx     = '0;
        if (clr_req) begin
          state_nx = ST_CLEAR;
        end else if (char_valid) begin
          accept   = 1'b1;
          state_nx = ST_DRAW;
        end
      end
      ST_CLEAR: begin
        write_en   = 1'b1;
        addr_write = cnt;
        data_write = CLEAR_BYTE;
        cnt_nx     = cnt + 10'd1;
        if (cnt == CLR_LAST) begin
          state_nx = ST_DONE;
        end
      end
      ST_DRAW: begin
        if (!cnt[3]) begin
          font_addr = {code_q, cnt[2:0]};
        end
        if (cnt != '0) begin
          write_en   = 1'b1;
          data_write = glyph_byte;
          addr_write = lcd_fb_addr(row_q, pix_col);
        end
        if (cnt == DRAW_LAST) begin
          cnt_nx   = '0;
          state_nx = ST_DONE;
        end else begin
          cnt_nx = cnt + 10'd1;
        end
      end
      ST_DONE: begin
        upd_done = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed self-checking bench for lcd_text_writer with a behavioural
// registered font ROM.
module tb_lcd_text_writer;
  import lcd_pkg::*;

  logic        sys_clk;
  logic        reset_o;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  char_code;
  logic [2:0]  char_row;
  logic [3:0]  char_col;
  logic        char_invert;
  logic        clr_req;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [9:0]  addr_write;
  logic [7:0]  data_write;
  logic        write_en;
  logic        busy;
  logic        upd_done;
  logic [1:0]  fsm_state;

  int n_total = 0;
  int n_bad   = 0;
  int rom_mode = 0;

  lcd_text_writer dut (
    .sys_clk    (sys_clk),
    .reset_o    (reset_o),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_code  (char_code),
    .char_row   (char_row),
    .char_col   (char_col),
`ifdef LCD_TEXT_INVERT_EN
    .char_invert(char_invert),
`endif
    .clr_req    (clr_req),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .addr_write (addr_write),
    .data_write (data_write),
    .write_en   (write_en),
    .busy       (busy),
    .upd_done   (upd_done),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // font ROM model: registered, one cycle latency
  function automatic logic [7:0] rom_byte(input logic [10:0] a);
    case (rom_mode)
      0:       return 8'hA0 + {5'b00000, a[2:0]};
      1:       return 8'h0F;
      default: return a[10:3] ^ {a[2:0], 5'b10101};
    endcase
  endfunction

  always @(posedge sys_clk) font_data <= rom_byte(font_addr);

  function automatic logic [9:0] exp_addr(input int row, input int col, input int k);
    logic [2:0] p;
    logic [6:0] c;
    p = 3'(row);
    c = 7'((col * 8 + k) % 128);
    return {~p[2:1], c, ~p[0]};
  endfunction

  // scoreboard check
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver: present a character and complete the handshake on the next edge
  task automatic send_char(input logic [7:0] code, input logic [2:0] row,
                           input logic [3:0] col, input logic inv, input logic hold);
    @(negedge sys_clk);
    char_code   = code;
    char_row    = row;
    char_col    = col;
    char_invert = inv;
    char_valid  = 1'b1;
    #1;
    check_val("ready_before_hs", char_ready, 1'b1);
    @(posedge sys_clk);
    #1;
    if (!hold) char_valid = 1'b0;
  endtask

  // called just after the handshake edge T; checks cycles T+1..T+10
  task automatic verify_draw(input logic [7:0] code, input int row, input int col,
                             input logic inv);
    logic [7:0] exp_q[$];
    logic [7:0] ed;
    for (int k = 0; k < 8; k++) begin
      ed = rom_byte({code, 3'(k)});
      exp_q.push_back(inv ? ~ed : ed);
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge sys_clk);
      check_val($sformatf("we_c%0d", c), write_en, (c >= 2 && c <= 9));
      check_val($sformatf("done_c%0d", c), upd_done, (c == 10));
      check_val($sformatf("busy_c%0d", c), busy, 1'b1);
      check_val($sformatf("ready_c%0d", c), char_ready, 1'b0);
      if (c <= 8) check_val($sformatf("faddr_c%0d", c), font_addr, {code, 3'(c - 1)});
      if (c >= 2 && c <= 9) begin
        check_val($sformatf("addr_c%0d", c), addr_write, exp_addr(row, col, c - 2));
        check_val($sformatf("data_c%0d", c), data_write, exp_q.pop_front());
      end
    end
  endtask

  task automatic quiet_cycles(input string tag, input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (write_en || upd_done || busy) hits++;
    end
    check_val(tag, hits, 0);
  endtask

  initial begin
    int good;
    int waited;
    reset_o     = 1'b0;
    char_valid  = 1'b0;
    char_code   = '0;
    char_row    = '0;
    char_col    = '0;
    char_invert = 1'b0;
    clr_req     = 1'b0;
    repeat (3) @(negedge sys_clk);

    // reset state
    check_val("rst_ready", char_ready, 1'b1);
    check_val("rst_we", write_en, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", upd_done, 1'b0);
    check_val("rst_addr", addr_write, 10'h000);
    check_val("rst_data", data_write, 8'h00);
    check_val("rst_faddr", font_addr, 11'h000);
    check_val("rst_state", fsm_state, ST_IDLE);
    reset_o = 1'b1;
    repeat (2) @(negedge sys_clk);

    // 1: 'A' at row 0 col 0, addresses 0x301..0x30F step 2
    rom_mode = 0;
    check_val("t1_addr0_hand", exp_addr(0, 0, 0), 10'h301);
    send_char(8'h41, 3'd0, 4'd0, 1'b0, 1'b0);
    verify_draw(8'h41, 0, 0, 1'b0);
    @(negedge sys_clk);
    check_val("t1_ready_T11", char_ready, 1'b1);
    check_val("t1_state_T11", fsm_state, ST_IDLE);

    // 2: bottom-right corner, addresses 0x0F0..0x0FE
    check_val("t2_addr0_hand", exp_addr(7, 15, 0), 10'h0F0);
    check_val("t2_addr7_hand", exp_addr(7, 15, 7), 10'h0FE);
    send_char(8'h7E, 3'd7, 4'd15, 1'b0, 1'b0);
    verify_draw(8'h7E, 7, 15, 1'b0);
    quiet_cycles("t2_quiet", 3);

    // 3: clear wins over a simultaneous char; char taken afterwards
    @(negedge sys_clk);
    clr_req    = 1'b1;
    char_valid = 1'b1;
    char_code  = 8'h33;
    char_row   = 3'd2;
    char_col   = 4'd6;
    #1;
    check_val("t3_ready_clr", char_ready, 1'b0);
    @(posedge sys_clk);
    #1;
    clr_req = 1'b0;
    good = 0;
    for (int c = 1; c <= 1024; c++) begin
      @(negedge sys_clk);
      if (write_en && addr_write == 10'(c - 1) && data_write == 8'h00 &&
          !upd_done && !char_ready && busy)
        good++;
    end
    check_val("t3_clear_writes", good, 1024);
    @(negedge sys_clk);
    check_val("t3_done", upd_done, 1'b1);
    check_val("t3_we_done", write_en, 1'b0);
    check_val("t3_ready_done", char_ready, 1'b0);
    waited = 0;
    while (!char_ready && waited < 20) begin
      @(negedge sys_clk);
      waited++;
    end
    check_val("t3_ready_after", char_ready, 1'b1);
    check_val("t3_idle_lat", waited, 1);
    @(posedge sys_clk);
    #1;
    char_valid = 1'b0;
    verify_draw(8'h33, 2, 6, 1'b0);
    quiet_cycles("t3_quiet", 3);

    // 4: valid held through DRAW -> exactly one more handshake at T+11
    rom_mode = 2;
    send_char(8'hC5, 3'd4, 4'd9, 1'b0, 1'b1);
    verify_draw(8'hC5, 4, 9, 1'b0);
    @(negedge sys_clk);
    check_val("t4_ready_T11", char_ready, 1'b1);
    @(posedge sys_clk);
    #1;
    char_valid = 1'b0;
    verify_draw(8'hC5, 4, 9, 1'b0);
    quiet_cycles("t4_once", 5);

    // 5: reset at DRAW cycle 4 aborts immediately
    rom_mode = 0;
    send_char(8'h12, 3'd5, 4'd3, 1'b0, 1'b0);
    repeat (5) @(negedge sys_clk);
    check_val("t5_we_before", write_en, 1'b1);
    check_val("t5_addr_before", addr_write, exp_addr(5, 3, 3));
    #2;
    reset_o = 1'b0;
    #1;
    check_val("t5_we_async", write_en, 1'b0);
    check_val("t5_busy_async", busy, 1'b0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    reset_o = 1'b1;
    quiet_cycles("t5_no_done", 12);
    check_val("t5_state", fsm_state, ST_IDLE);
    check_val("t5_ready", char_ready, 1'b1);

`ifdef LCD_TEXT_INVERT_EN
    // 6: reverse video, ROM 0x0F -> 0xF0 on every write
    rom_mode = 1;
    send_char(8'h20, 3'd3, 4'd5, 1'b1, 1'b0);
    verify_draw(8'h20, 3, 5, 1'b1);
    check_val("t6_inv_hand", ~rom_byte(11'h100), 8'hF0);
    quiet_cycles("t6_quiet", 2);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
